imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate, an immediate-format select and register/opcode fields, and packs them into a 32-bit RV32I instruction word.
- Flags any immediate the selected format cannot represent.
- Used by the instruction-injection / self-test path to build instruction words for the pcpu fetch stage.
- Two-stage valid/ready pipeline, throughput one word per cycle.

Parameters:
CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request
fmt  input  6  one-hot format: 100000 I-shamt, 010000 I, 001000 S, 000100 B, 000010 U, 000001 J
opcode  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7  input  7  instr[31:25], I-shamt only
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  32  full immediate value, as the extender would output it
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_err  output  1  immediate not representable, or fmt illegal
err_cnt  output  CNT_W  count of errored words delivered, saturating

Behaviour:
- Reset (rstn low, asynchronous) clears everything: stage valids, out_valid=0, out_instr=0, out_err=0, err_cnt=0, in_ready=1 after reset. A reset mid-stream drops in-flight words.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_instr and out_err hold stable while out_valid && !out_ready.
- Pipeline:
  - Stage 1 registers the range check and packed word.
  - Stage 2 is the output register.
  - Stage k advances when its successor is empty or is transferring this cycle.
  - in_ready = !s1_valid || s1_advance. in_ready must not depend on in_valid.
- Latency: a word accepted at edge N has out_valid=1 after edge N+1 when there is no backpressure. A new word can be accepted every cycle. Order is preserved, with no loss or duplication.
- Packing, imm bits used per format:
  - I-shamt: {funct7, imm[4:0], rs1, funct3, rd, opcode}. Legal iff imm[31:5]==0.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Legal iff imm[31:11] all equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Legal iff imm[31:11] all equal.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal iff imm[0]==0 and imm[31:12] all equal.
  - U: {imm[31:12], rd, opcode}. Legal iff imm[11:0]==0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Legal iff imm[0]==0 and imm[31:20] all equal.
- Illegal immediate: out_err=1. out_instr is still packed from the listed bits, which truncates the immediate.
- fmt not exactly one of the six codes (including 0 or multi-hot): out_instr=0, out_err=1.
- Round-trip property: for every legal input, feeding out_instr's fields back through the extender reproduces imm exactly.
- err_cnt increments by 1 on each output transfer with out_err=1. It saturates at all-ones and has no wrap-around.
- An input accept and an output transfer in the same cycle are both honoured.

Test Plan:
- ITYPE, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, out_err=0, out_valid two edges after accept.
- BTYPE, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7. J, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- ITYPE imm=0x800, rd=1, opcode=0x13 -> out_instr=0x80000093, out_err=1, err_cnt 0->1 on transfer. B imm=6 vs 7 -> err 0 vs 1. fmt=000011 -> out_instr=0, out_err=1.
- Backpressure:
  - out_ready=0, stream 3 requests back-to-back -> first two accepted, then in_ready=0 and the third is held.
  - out_instr is stable while stalled.
  - Raise out_ready -> all three emerge in order, one per cycle, none duplicated.
- Continuous streaming with out_ready=1, 16 random legal requests -> 16 outputs at one per cycle, each round-tripping through the extender to its original imm.
- Reset mid-operation:
  - Assert rstn=0 between edges with both stages full -> out_valid=0 and err_cnt=0 immediately, without waiting for clk.
  - After release, the next request is encoded normally.
  - Also force err_cnt to all-ones, then send one more errored word -> err_cnt stays at all-ones.

Source files
------------

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Packs an immediate plus register/opcode fields into an RV32I
//            instruction word, flagging immediates the format cannot hold.
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [5:0] c_FMT_ISH = 6'b100000;
    localparam logic [5:0] c_FMT_I   = 6'b010000;
    localparam logic [5:0] c_FMT_S   = 6'b001000;
    localparam logic [5:0] c_FMT_B   = 6'b000100;
    localparam logic [5:0] c_FMT_U   = 6'b000010;
    localparam logic [5:0] c_FMT_J   = 6'b000001;

    logic             r_s1_valid;
    logic [31:0]      r_s1_instr;
    logic             r_s1_err;
    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic             r_out_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_sx11;
    logic             w_sx12;
    logic             w_sx20;
    logic             w_out_xfer;
    logic             w_s1_adv;
    logic             w_in_xfer;

    // Upper bits must be a pure sign extension of the highest encoded bit.
    assign w_sx11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_sx12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_sx20 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        w_instr = 32'd0;
        w_err   = 1'b1;
        case (fmt)
            c_FMT_ISH: begin
                w_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                w_err   = |imm[31:5];
            end
            c_FMT_I: begin
                w_instr = {imm[11:0], rs1, funct3, rd, opcode};
                w_err   = ~w_sx11;
            end
            c_FMT_S: begin
                w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_err   = ~w_sx11;
            end
            c_FMT_B: begin
                w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_err   = imm[0] | ~w_sx12;
            end
            c_FMT_U: begin
                w_instr = {imm[31:12], rd, opcode};
                w_err   = |imm[11:0];
            end
            c_FMT_J: begin
                w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_err   = imm[0] | ~w_sx20;
            end
            default: begin
                w_instr = 32'd0;
                w_err   = 1'b1;
            end
        endcase
    end

    assign w_out_xfer = r_out_valid & out_ready;
    assign w_s1_adv   = r_s1_valid & (~r_out_valid | w_out_xfer);
    assign in_ready   = ~r_s1_valid | w_s1_adv;
    assign w_in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid  <= 1'b0;
            r_s1_instr  <= 32'd0;
            r_s1_err    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_instr <= w_instr;
                r_s1_err   <= w_err;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_out_instr <= r_s1_instr;
                r_out_err   <= r_s1_err;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_xfer && r_out_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Directed and streaming checks of imm_encoder packing, flow control
//            and error counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       fmt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_imm[$];
    logic [31:0] r_held;

    imm_encoder #(.CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference extender: recovers the immediate from an encoded word.
    function automatic logic [31:0] extend(input logic [5:0] f, input logic [31:0] i);
        case (f)
            6'b100000: extend = {27'd0, i[24:20]};
            6'b010000: extend = {{20{i[31]}}, i[31:20]};
            6'b001000: extend = {{20{i[31]}}, i[31:25], i[11:7]};
            6'b000100: extend = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            6'b000010: extend = {i[31:12], 12'd0};
            default:   extend = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    task automatic set_req(input logic [5:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    // Holds the request until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [5:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        int k;
        set_req(f, op, f3, f7, d, s1, s2, im);
        for (k = 0; k < 20; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (k == 20) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_instr, input logic e_err);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, e_instr);
        chk({tag, "_err"}, 32'(out_err), 32'(e_err));
    endtask

    task automatic expect_cnt(input string tag, input logic [CNT_W-1:0] e);
        @(posedge clk);
        #1 chk(tag, 32'(err_cnt), 32'(e));
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = 6'd0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // I-type with latency check
        send(6'b010000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("lat_first_negedge", 32'(out_valid), 32'd0);
        expect_out("itype", 32'hFFF0_0093, 1'b0);
        expect_cnt("cnt_after_legal", 4'd0);

        send(6'b000100, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_out("btype", 32'h0020_8463, 1'b0);
        send(6'b000010, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        expect_out("utype", 32'h1234_52B7, 1'b0);
        send(6'b000001, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        expect_out("jtype", 32'h0010_00EF, 1'b0);
        send(6'b001000, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
        expect_out("stype", 32'hFE51_2E23, 1'b0);
        send(6'b100000, 7'h13, 3'd5, 7'h20, 5'd3, 5'd2, 5'd0, 32'd3);
        expect_out("shamt", 32'h4031_5193, 1'b0);

        // Errored words
        send(6'b010000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        expect_out("itype_range", 32'h8000_0093, 1'b1);
        expect_cnt("cnt_1", 4'd1);
        send(6'b000100, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd6);
        expect_out("btype_even", 32'h0020_8363, 1'b0);
        send(6'b000100, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        expect_out("btype_odd", 32'h0020_8363, 1'b1);
        expect_cnt("cnt_2", 4'd2);
        send(6'b000011, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        expect_out("bad_fmt", 32'h0000_0000, 1'b1);
        send(6'b100000, 7'h13, 3'd5, 7'h20, 5'd3, 5'd2, 5'd0, 32'h20);
        expect_out("shamt_range", 32'h4001_5193, 1'b1);
        expect_cnt("cnt_4", 4'd4);

        // Backpressure: third request held, all three drain in order
        out_ready = 1'b0;
        send(6'b000010, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_1000);
        send(6'b000010, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_2000);
        set_req(6'b000010, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_3000);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head", out_instr, 32'h0000_1037);
        r_held = out_instr;
        @(negedge clk);
        chk("bp_stable", out_instr, r_held);
        chk("bp_still_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second", out_instr, 32'h0000_2037);
        chk("bp_second_v", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_third", out_instr, 32'h0000_3037);
        chk("bp_third_v", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming: 16 random legal requests, one per cycle
        @(posedge clk); #1;
        fork
            begin : producer
                for (int i = 0; i < 16; i++) begin
                    logic [31:0] r;
                    logic [31:0] im;
                    logic [5:0]  f;
                    int sel;
                    r   = $urandom;
                    sel = $urandom_range(0, 5);
                    f   = 6'b100000 >> sel;
                    case (sel)
                        0:       im = {27'd0, r[4:0]};
                        1, 2:    im = {{20{r[11]}}, r[11:0]};
                        3:       im = {{19{r[12]}}, r[12:1], 1'b0};
                        4:       im = {r[31:12], 12'd0};
                        default: im = {{11{r[20]}}, r[20:1], 1'b0};
                    endcase
                    q_imm.push_back(im);
                    q_imm.push_back({26'd0, f});
                    set_req(f, 7'h13, r[14:12], r[31:25], r[11:7], r[19:15], r[24:20], im);
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin : consumer
                int n = 0;
                int first = -1;
                int last = -1;
                for (int cyc = 0; cyc < 40; cyc++) begin
                    @(negedge clk);
                    if (out_valid && q_imm.size() >= 2) begin
                        logic [31:0] e_imm;
                        logic [31:0] e_fmt;
                        e_imm = q_imm.pop_front();
                        e_fmt = q_imm.pop_front();
                        chk("stream_roundtrip", extend(e_fmt[5:0], out_instr), e_imm);
                        chk("stream_err", 32'(out_err), 32'd0);
                        if (first < 0) first = cyc;
                        last = cyc;
                        n++;
                    end
                end
                chk("stream_count", 32'(n), 32'd16);
                chk("stream_rate", 32'(last - first), 32'd15);
            end
        join

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(6'b000000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        send(6'b000000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        #3 rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(6'b000010, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        expect_out("post_rst", 32'h1234_52B7, 1'b0);
        @(negedge clk);
        chk("post_rst_no_dup", 32'(out_valid), 32'd0);

        // Saturation of the error counter
        for (int i = 0; i < 15; i++) begin
            send(6'b000000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
            expect_out("sat_fill", 32'd0, 1'b1);
        end
        expect_cnt("cnt_full", 4'hF);
        send(6'b000000, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        expect_out("sat_extra", 32'd0, 1'b1);
        expect_cnt("cnt_saturated", 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
